// File: rtl/spi_master_if_pkg.sv
// Shared definitions for the byte-wide SPI master: link width, idle line
// levels, FSM state encodings and the bit-order helpers used by the shift
// registers.
package spi_master_if_pkg;

    localparam int DATA_W = 8;

    localparam logic SCK_IDLE  = 1'b1;
    localparam logic MOSI_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_HOLD  = 3'd4
    } spi_state_t;

    // Next bit to put on mosi: top of the shift register when MSB first,
    // bottom when LSB first.
    function automatic logic tx_bit(input logic [DATA_W-1:0] d, input logic msb_first);
        return msb_first ? d[DATA_W-1] : d[0];
    endfunction

    // Drop the bit just sent so the next one sits where tx_bit looks.
    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] d,
                                                   input logic msb_first);
        return msb_first ? {d[DATA_W-2:0], 1'b0} : {1'b0, d[DATA_W-1:1]};
    endfunction

    // Insert a received bit so the first one ends up in bit 7 (MSB first)
    // or bit 0 (LSB first) after a full byte.
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] d,
                                                   input logic msb_first,
                                                   input logic b);
        return msb_first ? {d[DATA_W-2:0], b} : {b, d[DATA_W-1:1]};
    endfunction

endpackage

// File: rtl/spi_master_if_if.sv
// Host handshake plus SPI pin bundle for the SPI master. The master modport
// is the view taken by spi_master_if; the slave modport is the far side
// (host driver plus attached serial device).
interface spi_master_if_if;
    import spi_master_if_pkg::*;

    logic              start;
    logic [DATA_W-1:0] tdata;
    logic              mlb;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              ss;
    logic              sck;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, tdata, mlb, miso,
        output busy, done, rdata, ss, sck, mosi
    );

    modport slave (
        output start, tdata, mlb, miso,
        input  busy, done, rdata, ss, sck, mosi
    );

endinterface

// File: rtl/spi_half_tick.sv
// Half-period timer: counts CLK_DIV clk cycles per FSM state visit and
// flags the last cycle of the visit. The counter restarts on its own tick
// and is held at zero while clr is high, so it never free-runs past its
// terminal value.
module spi_half_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Divider counter: cleared by reset, by clr, or when the visit ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr || tick) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/spi_master_if.sv
// Byte-wide SPI master. sck idles high; mosi changes with each sck falling
// edge and miso is sampled with each sck rising edge. Each FSM state lasts
// CLK_DIV clk cycles, so a frame is SETUP + 8x(LOW,HIGH) + HOLD = 18 visits
// and done fires 18*CLK_DIV edges after the accepting edge.
module spi_master_if
    import spi_master_if_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_master_if_if.master bus
);

    spi_state_t        state_r;
    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] rx_r;
    logic [DATA_W-1:0] rdata_r;
    logic [2:0]        bit_cnt_r;
    logic              mlb_r;
    logic              ss_r;
    logic              sck_r;
    logic              mosi_r;
    logic              busy_r;
    logic              done_r;
    logic              tick_s;
    logic              clr_s;

    // The timer is parked while idle so the first visit after accept is full length.
    assign clr_s = (state_r == ST_IDLE);

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Transfer FSM with shift registers, bit counter and registered pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            tx_r      <= {DATA_W{1'b0}};
            rx_r      <= {DATA_W{1'b0}};
            rdata_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= 3'd0;
            mlb_r     <= 1'b1;
            ss_r      <= 1'b1;
            sck_r     <= SCK_IDLE;
            mosi_r    <= MOSI_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        tx_r      <= bus.tdata;
                        mlb_r     <= bus.mlb;
                        rx_r      <= {DATA_W{1'b0}};
                        bit_cnt_r <= 3'd0;
                        ss_r      <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick_s) begin
                        sck_r   <= 1'b0;
                        mosi_r  <= tx_bit(tx_r, mlb_r);
                        tx_r    <= tx_shift(tx_r, mlb_r);
                        state_r <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tick_s) begin
                        sck_r   <= 1'b1;
                        rx_r    <= rx_shift(rx_r, mlb_r, bus.miso);
                        state_r <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick_s) begin
                        if (bit_cnt_r != 3'd7) begin
                            sck_r     <= 1'b0;
                            mosi_r    <= tx_bit(tx_r, mlb_r);
                            tx_r      <= tx_shift(tx_r, mlb_r);
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            state_r   <= ST_LOW;
                        end else begin
                            state_r   <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_s) begin
                        ss_r    <= 1'b1;
                        mosi_r  <= MOSI_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        rdata_r <= rx_r;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ss_r    <= 1'b1;
                    sck_r   <= SCK_IDLE;
                    mosi_r  <= MOSI_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ss    = ss_r;
    assign bus.sck   = sck_r;
    assign bus.mosi  = mosi_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_spi_master_if.sv
// Directed bench for spi_master_if: one instance at CLK_DIV=2, one at
// CLK_DIV=1, with miso either looped back from mosi or driven from a
// pattern on sck falling edges.
module tb_spi_master_if;
    import spi_master_if_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic miso_lb;
    logic miso_drv;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    spi_master_if_if b0 ();
    spi_master_if_if b1 ();

    assign b0.miso = miso_lb ? b0.mosi : miso_drv;
    assign b1.miso = miso_lb ? b1.mosi : miso_drv;

    spi_master_if #(.CLK_DIV(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    spi_master_if #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [7:0] td, input logic m);
        if (sel == 1) begin
            b1.start = st; b1.tdata = td; b1.mlb = m;
        end else begin
            b0.start = st; b0.tdata = td; b0.mlb = m;
        end
    endtask

    // One frame: returns mosi bits in send order (first bit in [7]),
    // cycles from accept to done, rdata at done, done count and ss at c=0.
    task automatic xfer(input int sel, input logic [7:0] td, input logic m,
                        input logic [7:0] mpat, input bit lb, input bit pre,
                        input bit chain, input logic [7:0] next_td, input bit spam,
                        output logic [7:0] mosi_bits, output int lat,
                        output logic [7:0] rd, output int ndone, output logic ss0);
        logic prev_sck;
        logic s_sck, s_mosi, s_done, s_ss;
        logic [7:0] s_rd;
        int idx;
        prev_sck = 1'b1; idx = 0;
        miso_lb = lb; miso_drv = 1'b1;
        mosi_bits = 8'h00; lat = -1; rd = 8'h00; ndone = 0; ss0 = 1'bx;
        if (!pre) begin
            @(negedge clk);
            drive(sel, 1'b1, td, m);
        end
        @(posedge clk);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) drive(sel, 1'b0, td, m);
            if (spam) begin
                if (c == 5 || c == 11 || c == 17) drive(sel, 1'b1, 8'hFF, ~m);
                else drive(sel, 1'b0, td, m);
            end
            s_sck  = (sel == 1) ? b1.sck   : b0.sck;
            s_mosi = (sel == 1) ? b1.mosi  : b0.mosi;
            s_done = (sel == 1) ? b1.done  : b0.done;
            s_ss   = (sel == 1) ? b1.ss    : b0.ss;
            s_rd   = (sel == 1) ? b1.rdata : b0.rdata;
            if (c == 0) ss0 = s_ss;
            if (prev_sck && !s_sck) begin
                mosi_bits = {mosi_bits[6:0], s_mosi};
                if (!lb && idx < 8) begin
                    miso_drv = mpat[idx];
                    idx++;
                end
            end
            prev_sck = s_sck;
            if (s_done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    rd  = s_rd;
                end
                if (chain) begin
                    drive(sel, 1'b1, next_td, m);
                    break;
                end
            end
            if (lat >= 0 && c >= lat + 3) break;
        end
        if (!chain) drive(sel, 1'b0, td, m);
    endtask

    logic [7:0] mb;
    logic [7:0] rd;
    logic       ss0;
    int         lat;
    int         nd;
    int         rises;
    int         ndone_after;
    logic       prev;

    initial begin
        rst = 1'b1; miso_lb = 1'b1; miso_drv = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b1);
        drive(1, 1'b0, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ss",    32'(b0.ss),    32'h1);
        chk("rst_sck",   32'(b0.sck),   32'h1);
        chk("rst_mosi",  32'(b0.mosi),  32'h1);
        chk("rst_busy",  32'(b0.busy),  32'h0);
        chk("rst_done",  32'(b0.done),  32'h0);
        chk("rst_rdata", 32'(b0.rdata), 32'h0);
        chk("rst_sck_d1", 32'(b1.sck),  32'h1);
        rst = 1'b0;

        // 1: MSB first, loopback
        xfer(0, 8'h7C, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, mb, lat, rd, nd, ss0);
        chk("t1_mosi",  32'(mb),  32'h7C);
        chk("t1_rdata", 32'(rd),  32'h7C);
        chk("t1_lat",   32'(lat), 32'd36);
        chk("t1_ndone", 32'(nd),  32'd1);
        chk("t1_ss0",   32'(ss0), 32'h0);

        // 2: LSB first, miso from A5 LSB-first
        xfer(0, 8'h70, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, mb, lat, rd, nd, ss0);
        chk("t2_mosi",  32'(mb),  32'h0E);
        chk("t2_rdata", 32'(rd),  32'hA5);
        chk("t2_lat",   32'(lat), 32'd36);

        // 3: reset on the 4th sck rising edge
        miso_lb = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 8'hC3, 1'b1);
        @(posedge clk);
        rises = 0; prev = 1'b1;
        for (int c = 0; c < 100 && rises < 4; c++) begin
            @(negedge clk);
            drive(0, 1'b0, 8'hC3, 1'b1);
            if (!prev && b0.sck) rises++;
            prev = b0.sck;
        end
        chk("t3_rises", 32'(rises), 32'd4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t3_ss",    32'(b0.ss),    32'h1);
        chk("t3_sck",   32'(b0.sck),   32'h1);
        chk("t3_mosi",  32'(b0.mosi),  32'h1);
        chk("t3_busy",  32'(b0.busy),  32'h0);
        chk("t3_rdata", 32'(b0.rdata), 32'h0);
        rst = 1'b0;
        ndone_after = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (b0.done) ndone_after++;
        end
        chk("t3_nodone", 32'(ndone_after), 32'd0);

        // 4: start pulses while busy are ignored
        xfer(0, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, mb, lat, rd, nd, ss0);
        chk("t4_mosi",  32'(mb), 32'h5A);
        chk("t4_rdata", 32'(rd), 32'h5A);
        chk("t4_ndone", 32'(nd), 32'd1);

        // 5: back-to-back frames with start held through done
        xfer(0, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, mb, lat, rd, nd, ss0);
        chk("t5a_mosi",  32'(mb),    32'hC3);
        chk("t5a_rdata", 32'(rd),    32'hC3);
        chk("t5a_lat",   32'(lat),   32'd36);
        chk("t5_ss_gap", 32'(b0.ss), 32'h1);
        xfer(0, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, mb, lat, rd, nd, ss0);
        chk("t5b_ss0",   32'(ss0), 32'h0);
        chk("t5b_mosi",  32'(mb),  32'h3C);
        chk("t5b_rdata", 32'(rd),  32'h3C);
        chk("t5b_lat",   32'(lat), 32'd36);
        chk("t5b_ndone", 32'(nd),  32'd1);

        // 6: CLK_DIV=1 instance
        xfer(1, 8'h81, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, mb, lat, rd, nd, ss0);
        chk("t6_mosi",  32'(mb),  32'h81);
        chk("t6_rdata", 32'(rd),  32'h81);
        chk("t6_lat",   32'(lat), 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
